// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants for the fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int unsigned  INSTR_W      = 32;
    localparam int unsigned  PC_STEP_DEF  = 4;
    localparam logic [63:0]  RESET_PC_DEF = 64'h0;
    localparam logic [4:0]   OPC_HALT     = 5'h1F;

    function automatic logic is_halt_opc(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 5] == OPC_HALT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module   : fetch_buffer
// Brief    : Output slot plus one prefetch slot behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                ready,
    input  logic                load,
    input  logic [INSTR_W-1:0]  load_instr,
    input  logic [ADDR_W-1:0]   load_pc,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   pc,
    output logic                instr_valid,
    output logic                pf_valid
);

    logic [INSTR_W-1:0] pf_instr;
    logic [ADDR_W-1:0]  pf_pc;
    logic               advance;

    // Output slot may be refilled when it is empty or being consumed now.
    assign advance = ~instr_valid | ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr       <= '0;
            pc          <= '0;
            instr_valid <= 1'b0;
            pf_instr    <= '0;
            pf_pc       <= '0;
            pf_valid    <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
            pf_valid    <= 1'b0;
        end else if (advance) begin
            if (pf_valid) begin
                instr       <= pf_instr;
                pc          <= pf_pc;
                instr_valid <= 1'b1;
                pf_valid    <= load;
                pf_instr    <= load_instr;
                pf_pc       <= load_pc;
            end else if (load) begin
                instr       <= load_instr;
                pc          <= load_pc;
                instr_valid <= 1'b1;
            end else begin
                instr_valid <= 1'b0;
            end
        end else if (load) begin
            pf_instr <= load_instr;
            pf_pc    <= load_pc;
            pf_valid <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : PC owner issuing single-outstanding imem reads toward decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                imem_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                pc_src,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                halt,
    output logic                halted
);

    logic [ADDR_W-1:0] fetch_pc;
    logic              out_req;
    logic              drop;
    logic              pf_valid;
    logic              accept;
    logic              halt_now;
    logic              redirect;
    logic              flush;
    logic              resp;
    logic              deliver;
    logic              issue;

    always_comb begin
        accept   = instr_valid & instr_ready;
        halt_now = accept & halt;
        redirect = accept & pc_src & ~halt;
        flush    = halt_now | redirect;
        resp     = imem_valid & out_req;
        // A response coinciding with a flush belongs to the old stream.
        deliver  = resp & ~drop & ~flush & ~halted;
        issue    = ~halted & ~out_req & ~pf_valid & ~flush;
    end

    fetch_buffer #(
        .ADDR_W (ADDR_W)
    ) u_fetch_buffer (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .ready       (instr_ready),
        .load        (deliver),
        .load_instr  (imem_rdata),
        .load_pc     (imem_addr),
        .instr       (instr),
        .pc          (pc),
        .instr_valid (instr_valid),
        .pf_valid    (pf_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
            imem_req  <= 1'b0;
            out_req   <= 1'b0;
            drop      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            imem_req <= issue;
            if (issue) begin
                imem_addr <= fetch_pc;
                fetch_pc  <= fetch_pc + ADDR_W'(PC_STEP);
                out_req   <= 1'b1;
            end else if (resp) begin
                out_req <= 1'b0;
            end
            if (redirect) begin
                fetch_pc <= branch_target;
            end
            // Mark a read still in flight across a redirect so its word is discarded.
            if (resp) begin
                drop <= 1'b0;
            end else if (redirect) begin
                drop <= out_req;
            end
            if (halt_now) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Randomized self-checking bench for instr_fetch with an in-order model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam int unsigned AW   = 64;
    localparam logic [63:0] NONE = '1;

    logic          clk           = 1'b0;
    logic          reset         = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata    = '0;
    logic          imem_valid    = 1'b0;
    logic [31:0]   instr;
    logic [AW-1:0] pc;
    logic          instr_valid;
    logic          instr_ready   = 1'b0;
    logic          pc_src        = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          halt          = 1'b0;
    logic          halted;

    instr_fetch #(
        .ADDR_W   (AW),
        .RESET_PC (64'h0),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .instr         (instr),
        .pc            (pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .halt          (halt),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction memory contents as a pure function of the byte address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'd4)  return 32'h0800_1000;
        if (a == 64'd12) return 32'hF800_0000;
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h1357_0000;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        t = {$urandom, $urandom};
        if ($urandom_range(3, 0) == 0)
            t = 64'hFFFF_FFFF_FFFF_FFE0 | (64'($urandom_range(7, 0)) << 2);
        return {t[63:2], 2'b00};
    endfunction

    // imem responder state
    bit            pend;
    int            pend_cnt;
    logic [63:0]   pend_addr;
    int unsigned   lat_lo = 1, lat_hi = 1;
    logic [63:0]   req_log[$];

    // consumer controls and reference state
    int unsigned   ready_pct = 100;
    int unsigned   redir_pct = 0;
    logic [63:0]   hold_pc, redir_pc, redir_tgt, halt_pc, target_watch;
    int            hold_left, hold_reqs;
    bit            redir_on_valid, t4_hit, saw_target;
    logic [63:0]   exp_pc, prev_pc;
    bit            exp_halted, prev_stall, redir_open;
    int            cyc, redir_cyc, delivered;

    task automatic step();
        bit          busy, rd, ps, ht, acc;
        logic [63:0] tgt;
        @(posedge clk);
        #1;
        cyc++;
        busy       = pend;
        imem_valid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(pend_addr);
                pend       = 1'b0;
            end
        end
        if (imem_req) begin
            check("one_outstanding", 64'(busy), 64'd0);
            check("req_while_halted", 64'(exp_halted), 64'd0);
            req_log.push_back(imem_addr);
            if (instr_valid && exp_pc == hold_pc) hold_reqs++;
            pend      = 1'b1;
            pend_cnt  = int'($urandom_range(lat_hi, lat_lo));
            pend_addr = imem_addr;
        end

        check("halted", 64'(halted), 64'(exp_halted));
        if (exp_halted) check("valid_after_halt", 64'(instr_valid), 64'd0);
        if (prev_stall) begin
            check("stall_valid", 64'(instr_valid), 64'd1);
            check("stall_pc", pc, prev_pc);
        end
        if (instr_valid && !exp_halted) begin
            check("pc_order", pc, exp_pc);
            check("instr_word", 64'(instr), 64'(mem_word(exp_pc)));
            if (exp_pc == target_watch) saw_target = 1'b1;
            if (redir_open) begin
                check("redirect_latency", 64'(cyc - redir_cyc >= 2), 64'd1);
                redir_open = 1'b0;
            end
        end

        rd = ($urandom_range(99, 0) < ready_pct);
        if (instr_valid && exp_pc == hold_pc && hold_left > 0) begin
            rd = 1'b0;
            hold_left--;
        end
        if (redir_on_valid) rd = instr_valid && imem_valid;
        acc = instr_valid && rd;
        ps  = 1'b0;
        ht  = 1'b0;
        tgt = rand_target();
        if (acc) begin
            if (redir_on_valid) begin
                ps = 1'b1; tgt = redir_tgt; redir_on_valid = 1'b0; t4_hit = 1'b1;
            end else if (exp_pc == redir_pc) begin
                ps = 1'b1; tgt = redir_tgt; redir_pc = NONE;
            end else if (exp_pc == halt_pc) begin
                ht = 1'b1;
            end else if ($urandom_range(99, 0) < redir_pct) begin
                ps = 1'b1;
            end
        end else begin
            // Sideband noise outside an accept must have no effect.
            ps = $urandom_range(1, 0) == 1;
            ht = $urandom_range(1, 0) == 1;
        end
        instr_ready   = rd;
        pc_src        = ps;
        halt          = ht;
        branch_target = tgt;

        prev_stall = instr_valid && !rd && !exp_halted;
        prev_pc    = exp_pc;
        if (acc) begin
            delivered++;
            if (ht) begin
                exp_halted = 1'b1;
            end else if (ps) begin
                exp_pc     = tgt;
                redir_open = 1'b1;
                redir_cyc  = cyc;
            end else begin
                exp_pc = exp_pc + 64'd4;
            end
        end
    endtask

    task automatic do_reset(input bit stray);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        instr_ready = 1'b0;
        pc_src      = 1'b0;
        halt        = 1'b0;
        imem_valid  = 1'b0;
        #1;
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_addr", imem_addr, 64'd0);
        check("rst_pc", pc, 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        imem_valid = stray;
        imem_rdata = 32'hDEAD_BEEF;
        pend = 1'b0; exp_pc = 64'd0; exp_halted = 1'b0; prev_stall = 1'b0; redir_open = 1'b0;
        hold_pc = NONE; hold_left = 0; hold_reqs = 0; redir_pc = NONE; halt_pc = NONE;
        redir_on_valid = 1'b0; t4_hit = 1'b0; saw_target = 1'b0; target_watch = NONE;
        delivered = 0;
        req_log.delete();
    endtask

    initial begin
        // Sequential streaming at latency 1
        do_reset(1'b0);
        repeat (20) step();
        check("t1_req_count", 64'(req_log.size() >= 3), 64'd1);
        if (req_log.size() >= 3) begin
            check("t1_req0", req_log[0], 64'd0);
            check("t1_req1", req_log[1], 64'd4);
            check("t1_req2", req_log[2], 64'd8);
        end
        check("t1_progress", 64'(delivered >= 3), 64'd1);

        // Stall at pc 4: prefetch fills once, then no further reads
        do_reset(1'b0);
        hold_pc = 64'd4; hold_left = 5;
        repeat (25) step();
        check("t2_hold_done", 64'(hold_left), 64'd0);
        check("t2_hold_reqs", 64'(hold_reqs), 64'd1);
        check("t2_progress", 64'(delivered >= 4), 64'd1);

        // Redirect at pc 8 while the read for 12 is in flight
        do_reset(1'b0);
        lat_lo = 3; lat_hi = 3;
        hold_pc = 64'd8; hold_left = 2;
        redir_pc = 64'd8; redir_tgt = 64'h100; target_watch = 64'h100;
        repeat (50) step();
        check("t3_redirected", redir_pc, NONE);
        check("t3_target_seen", 64'(saw_target), 64'd1);

        // Redirect coinciding with imem_valid
        do_reset(1'b0);
        lat_lo = 1; lat_hi = 1;
        redir_on_valid = 1'b1; redir_tgt = 64'h200; target_watch = 64'h200;
        repeat (30) step();
        check("t4_same_cycle", 64'(t4_hit), 64'd1);
        check("t4_target_seen", 64'(saw_target), 64'd1);

        // Halt, quiet period, then restart from reset
        do_reset(1'b0);
        halt_pc = 64'd12;
        repeat (40) step();
        check("t5_halted", 64'(halted), 64'd1);
        do_reset(1'b0);
        repeat (10) step();
        check("t5_restart_reqs", 64'(req_log.size() >= 1), 64'd1);
        if (req_log.size() >= 1) check("t5_restart_addr", req_log[0], 64'd0);

        // Reset while a read is outstanding, followed by a stray response
        do_reset(1'b0);
        lat_lo = 3; lat_hi = 3;
        repeat (2) step();
        do_reset(1'b1);
        lat_lo = 1; lat_hi = 1;
        repeat (15) step();
        check("t6_progress", 64'(delivered >= 2), 64'd1);

        // Randomized latency, backpressure and redirects
        do_reset(1'b0);
        lat_lo = 1; lat_hi = 4; ready_pct = 60; redir_pct = 10;
        repeat (3000) step();
        check("t7_progress", 64'(delivered >= 200), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
